wb_branch_resolve: RTL and testbench
====================================

Name: wb_branch_resolve

Overview:
Consumer end of the execute-stage output bundle. Takes the registered ALU result, the load data and the control tags from execute, and produces the register-file write port. It also resolves branches from the compare result, issuing a PC redirect to fetch and squashing younger in-flight instructions. It sits between execute and the register file / fetch.

Parameters:
DATA_WIDTH, 32, register and load-data width
REG_ADDR_WIDTH, 5, register address width
PC_WIDTH, 16, branch target width
FLUSH_DEPTH, 8, number of younger instructions in flight behind a taken branch (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
p_i  in  37  execute result; [36] = sign, [35:0] = value
regwrite_i  in  1  instruction writes rd
regwriteui_i  in  1  upper-immediate write
sr_i  in  1  set-result instruction
cmpsel_i  in  1  set-result flag select: 1 = zero flag, 0 = sign flag
rd_addr_i  in  REG_ADDR_WIDTH  destination register
dm_re_i  in  1  load instruction
loadtype_i  in  3  load format
dm_regfile_data_i  in  DATA_WIDTH  word read from data memory
branchen_i  in  1  branch instruction
branchtype_i  in  3  branch condition
branchtarget_i  in  PC_WIDTH  branch target
rf_we_o  out  1  register-file write enable
rf_addr_o  out  REG_ADDR_WIDTH  write address
rf_data_o  out  DATA_WIDTH  write data
br_taken_o  out  1  one-cycle redirect pulse
br_pc_o  out  PC_WIDTH  redirect target, valid while br_taken_o = 1
flush_o  out  1  high while squashing

Behaviour:
- Reset (rst == 0 at a clk edge): all outputs go to 0, the FSM goes to IDLE and the squash counter to 0. Reset takes effect even mid-squash.
- All outputs are registered. Latency is 1 cycle from inputs to rf_*/br_*.
- Flags, computed combinationally from the inputs:
  - zero = (p_i[31:0] == 0)
  - neg = p_i[36]
- Write-data priority, highest first:
  - dm_re_i: formatted load data.
  - sr_i: {31'b0, cmpsel_i ? zero : neg}.
  - regwriteui_i: {p_i[15:0], 16'b0}.
  - otherwise: p_i[31:0].
- Load format, little-endian. The byte is selected by off = p_i[1:0]; the half-word by p_i[1].
  - 000 LW: full word.
  - 001 LH: sign-extended half-word.
  - 010 LHU: zero-extended half-word.
  - 011 LB: sign-extended byte.
  - 100 LBU: zero-extended byte.
  - 101..111: treated as LW.
- Write enable: rf_we_o = (regwrite_i | regwriteui_i | sr_i | dm_re_i) & (rd_addr_i != 0) & (state == IDLE).
- Branch condition (branchtype_i):
  - 000 EQ: zero.
  - 001 NE: !zero.
  - 010 LT: neg.
  - 011 GE: !neg.
  - 100 JMP: always taken.
  - 101..111: never taken.
- FSM:
  - IDLE: if branchen_i and the condition is true, then at the next edge br_taken_o = 1, br_pc_o = branchtarget_i, flush_o = 1, cnt = FLUSH_DEPTH - 1, and the state goes to SQUASH. If FLUSH_DEPTH == 1, the state stays IDLE and flush_o is a 1-cycle pulse.
  - SQUASH: each cycle the incoming instruction is discarded, with no rf write and no branch evaluation. cnt decrements. flush_o stays 1. br_taken_o = 0.
  - When SQUASH exits (cnt == 0): return to IDLE and drop flush_o at the next edge.
- Total squash window: exactly FLUSH_DEPTH cycles following the branch cycle.
- Simultaneous events:
  - A branch that also carries a write is an instruction that both writes and branches (link). Its rf write completes normally in the same cycle as br_taken_o.
  - A branch arriving during SQUASH is ignored.
- br_pc_o holds its last value when br_taken_o = 0.

Decomposition:
- Shared package: the LOAD_* and BR_* encodings, FLUSH_DEPTH default, DATA_WIDTH, REG_ADDR_WIDTH.
- One sub-module, load_format: combinational word, off, loadtype -> formatted data. This unit is reused by any future bypass path.

Test Plan:
- Reset mid-squash: force a taken JMP, release it, assert rst for 1 cycle during SQUASH. Next cycle: flush_o = 0, state IDLE, and a following regwrite to r3 of 0x5 writes.
- ALU write: regwrite_i = 1, rd = 7, p_i = 0x0_1234_5678 -> one cycle later rf_we_o = 1, addr 7, data 0x12345678. Repeat with rd = 0 -> rf_we_o = 0.
- Loads: mem word 0x80FF_7F01. Expected results:
  - LB, off 1 -> 0x0000007F.
  - LB, off 3 -> 0xFFFFFF80.
  - LHU, off 2 -> 0x000080FF.
  - LH, off 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Set-result and upper-immediate:
  - sr_i with p_i[36] = 1, cmpsel_i = 0 -> data 0x1.
  - sr_i with cmpsel_i = 1, p_i = 0 -> data 0x1.
  - regwriteui_i with p_i = 0xABCD -> 0xABCD0000.
- Branch EQ taken: p_i = 0, target 0x0040 -> br_taken_o pulse 1 cycle, br_pc_o = 0x0040, and flush_o high for exactly 8 cycles. Eight back-to-back regwrites are suppressed; the 9th writes.
- Branch not taken and reserved type:
  - BNE with p_i = 0 -> no br_taken_o, no flush.
  - type 101 with p_i = 0 -> no br_taken_o, no flush.
  - A second taken branch inside the squash window -> ignored; flush_o still ends after 8 cycles.

Source files
------------

// File: rtl/wb_branch_resolve_pkg.sv
// Shared definitions for the write-back / branch-resolve slice.
// Contents:
//   - Default widths and the default squash depth.
//   - Load-format (LOAD_*) encodings.
//   - Branch-condition (BR_*) encodings.
//   - The resolver state type.
package wb_branch_resolve_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_PC_WIDTH       = 16;
  localparam int DEF_FLUSH_DEPTH    = 8;

  // Four bits covers the full 1..15 range of squash depths.
  localparam int CNT_WIDTH = 4;

  localparam logic [2:0] LOAD_LW  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LHU = 3'b010;
  localparam logic [2:0] LOAD_LB  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b010;
  localparam logic [2:0] BR_GE  = 3'b011;
  localparam logic [2:0] BR_JMP = 3'b100;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_branch_resolve_load_format.sv
// load_format: purely combinational little-endian load formatter.
// Ports:
//   word     - raw word read from data memory
//   off      - byte offset within the word; bit 1 selects the half-word
//   loadtype - LOAD_* encoding; unknown encodings behave as a full-word load
//   data     - formatted, sign- or zero-extended result
module load_format
  import wb_branch_resolve_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            off,
  input  logic [2:0]            loadtype,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    half_sel = off[1] ? word[31:16] : word[15:0];

    case (loadtype)
      LOAD_LH:  data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      LOAD_LHU: data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      LOAD_LB:  data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/wb_branch_resolve.sv
// wb_branch_resolve: consumer end of the execute-stage bundle.
// Drives the register-file write port and resolves branches, redirecting
// fetch and squashing the younger instructions already in flight.
// Ports:
//   clk, rst           - clock; synchronous active-low reset
//   p_i                - execute result, [36] sign, [35:0] value
//   regwrite_i         - plain register write
//   regwriteui_i       - upper-immediate write
//   sr_i, cmpsel_i     - set-result write; cmpsel_i picks zero (1) or sign (0)
//   rd_addr_i          - destination register
//   dm_re_i            - load; loadtype_i and dm_regfile_data_i format it
//   branchen_i         - branch; branchtype_i condition, branchtarget_i target
//   rf_we_o/addr/data  - registered register-file write port
//   br_taken_o, br_pc_o- one-cycle redirect pulse and its (held) target
//   flush_o            - high while younger instructions are being discarded
module wb_branch_resolve
  import wb_branch_resolve_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int PC_WIDTH       = DEF_PC_WIDTH,
  parameter int FLUSH_DEPTH    = DEF_FLUSH_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [36:0]               p_i,
  input  logic                      regwrite_i,
  input  logic                      regwriteui_i,
  input  logic                      sr_i,
  input  logic                      cmpsel_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      dm_re_i,
  input  logic [2:0]                loadtype_i,
  input  logic [DATA_WIDTH-1:0]     dm_regfile_data_i,
  input  logic                      branchen_i,
  input  logic [2:0]                branchtype_i,
  input  logic [PC_WIDTH-1:0]       branchtarget_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_data_o,
  output logic                      br_taken_o,
  output logic [PC_WIDTH-1:0]       br_pc_o,
  output logic                      flush_o
);

  wb_state_e            state;
  logic [CNT_WIDTH-1:0] cnt;

  logic                  zero;
  logic                  neg;
  logic                  br_cond;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] wr_data;

  // The upper value bits of p_i carry nothing this stage consumes.
  logic unused_p_bits;
  assign unused_p_bits = ^p_i[35:32];

  load_format #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_format (
    .word    (dm_regfile_data_i),
    .off     (p_i[1:0]),
    .loadtype(loadtype_i),
    .data    (load_data)
  );

  // Flags, branch condition and write-data selection. Loads win over
  // set-result, which wins over upper-immediate, which wins over the ALU value.
  always_comb begin
    zero   = (p_i[31:0] == 32'd0);
    neg    = p_i[36];
    wr_req = regwrite_i | regwriteui_i | sr_i | dm_re_i;

    case (branchtype_i)
      BR_EQ:   br_cond = zero;
      BR_NE:   br_cond = !zero;
      BR_LT:   br_cond = neg;
      BR_GE:   br_cond = !neg;
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase

    if (dm_re_i)
      wr_data = load_data;
    else if (sr_i)
      wr_data = {{(DATA_WIDTH-1){1'b0}}, (cmpsel_i ? zero : neg)};
    else if (regwriteui_i)
      wr_data = DATA_WIDTH'({p_i[15:0], 16'h0000});
    else
      wr_data = DATA_WIDTH'(p_i[31:0]);
  end

  // Resolver FSM with registered outputs. A taken branch in IDLE pulses the
  // redirect, raises flush and loads the counter with FLUSH_DEPTH-1; SQUASH
  // then discards one instruction per cycle until the counter has run out,
  // giving a flush window of exactly FLUSH_DEPTH cycles. A branch that also
  // writes (link) still performs its write in the redirect cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rf_we_o    <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
      br_taken_o <= 1'b0;
      br_pc_o    <= '0;
      flush_o    <= 1'b0;
    end else begin
      rf_addr_o  <= rd_addr_i;
      rf_data_o  <= wr_data;
      br_taken_o <= 1'b0;

      case (state)
        IDLE: begin
          rf_we_o <= wr_req & (rd_addr_i != '0);
          if (branchen_i && br_cond) begin
            br_taken_o <= 1'b1;
            br_pc_o    <= branchtarget_i;
            flush_o    <= 1'b1;
            cnt        <= CNT_WIDTH'(FLUSH_DEPTH - 1);
            if (FLUSH_DEPTH > 1)
              state <= SQUASH;
          end else begin
            flush_o <= 1'b0;
          end
        end

        SQUASH: begin
          rf_we_o <= 1'b0;
          if (cnt == '0) begin
            state   <= IDLE;
            flush_o <= 1'b0;
          end else begin
            cnt     <= cnt - 1'b1;
            flush_o <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          rf_we_o <= 1'b0;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_branch_resolve.sv
// Self-checking bench for wb_branch_resolve: each applied vector pushes its
// expected outcome onto a scoreboard, which is popped after the clock edge.
module tb_wb_branch_resolve;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [36:0] p_i = '0;
  logic        regwrite_i = 1'b0;
  logic        regwriteui_i = 1'b0;
  logic        sr_i = 1'b0;
  logic        cmpsel_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        dm_re_i = 1'b0;
  logic [2:0]  loadtype_i = '0;
  logic [31:0] dm_regfile_data_i = '0;
  logic        branchen_i = 1'b0;
  logic [2:0]  branchtype_i = '0;
  logic [15:0] branchtarget_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        br_taken_o;
  logic [15:0] br_pc_o;
  logic        flush_o;

  wb_branch_resolve #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(16), .FLUSH_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .p_i(p_i), .regwrite_i(regwrite_i),
    .regwriteui_i(regwriteui_i), .sr_i(sr_i), .cmpsel_i(cmpsel_i),
    .rd_addr_i(rd_addr_i), .dm_re_i(dm_re_i), .loadtype_i(loadtype_i),
    .dm_regfile_data_i(dm_regfile_data_i), .branchen_i(branchen_i),
    .branchtype_i(branchtype_i), .branchtarget_i(branchtarget_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .br_taken_o(br_taken_o), .br_pc_o(br_pc_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [36:0] p;
    logic        rw, rwui, sr, cmpsel, re, be;
    logic [4:0]  rd;
    logic [2:0]  lt, bt;
    logic [31:0] mem;
    logic [15:0] tgt;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        br;
    logic [15:0] pc;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_left = 0;
  logic [15:0] m_pc = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic vec_t nop();
    vec_t v;
    v.p = '0; v.rw = 0; v.rwui = 0; v.sr = 0; v.cmpsel = 0; v.re = 0;
    v.be = 0; v.rd = '0; v.lt = '0; v.bt = '0; v.mem = '0; v.tgt = '0;
    return v;
  endfunction

  // Reference formatting of the value an instruction should write.
  function automatic logic [31:0] model_data(input vec_t v);
    logic [31:0] b, h;
    b = v.mem >> (8 * int'(v.p[1:0]));
    h = v.mem >> (16 * int'(v.p[1]));
    if (v.re) begin
      case (v.lt)
        3'b001:  return {{16{h[15]}}, h[15:0]};
        3'b010:  return {16'h0, h[15:0]};
        3'b011:  return {{24{b[7]}}, b[7:0]};
        3'b100:  return {24'h0, b[7:0]};
        default: return v.mem;
      endcase
    end
    if (v.sr) return {31'b0, v.cmpsel ? (v.p[31:0] == 32'd0) : v.p[36]};
    if (v.rwui) return {v.p[15:0], 16'h0};
    return v.p[31:0];
  endfunction

  task automatic applyStimulus(input string tag, input vec_t v);
    exp_t e, got;
    logic zero, neg, cond;
    @(negedge clk);
    p_i = v.p; regwrite_i = v.rw; regwriteui_i = v.rwui; sr_i = v.sr;
    cmpsel_i = v.cmpsel; rd_addr_i = v.rd; dm_re_i = v.re; loadtype_i = v.lt;
    dm_regfile_data_i = v.mem; branchen_i = v.be; branchtype_i = v.bt;
    branchtarget_i = v.tgt;

    zero = (v.p[31:0] == 32'd0);
    neg  = v.p[36];
    e = '0;
    if (m_left > 0) begin
      m_left--;
      e.flush = (m_left > 0);
    end else begin
      e.we   = (v.rw | v.rwui | v.sr | v.re) && (v.rd != 5'd0);
      e.addr = v.rd;
      e.data = model_data(v);
      case (v.bt)
        3'b000:  cond = zero;
        3'b001:  cond = !zero;
        3'b010:  cond = neg;
        3'b011:  cond = !neg;
        3'b100:  cond = 1'b1;
        default: cond = 1'b0;
      endcase
      if (v.be && cond) begin
        e.br = 1'b1; e.flush = 1'b1; m_pc = v.tgt; m_left = DEPTH;
      end
    end
    e.pc = m_pc;
    sb.push_back(e);

    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      checkOutput({tag, "_we"}, 32'(rf_we_o), 32'(got.we));
      if (got.we) begin
        checkOutput({tag, "_addr"}, 32'(rf_addr_o), 32'(got.addr));
        checkOutput({tag, "_data"}, rf_data_o, got.data);
      end
      checkOutput({tag, "_br"}, 32'(br_taken_o), 32'(got.br));
      checkOutput({tag, "_pc"}, 32'(br_pc_o), 32'(got.pc));
      checkOutput({tag, "_flush"}, 32'(flush_o), 32'(got.flush));
    end
  endtask

  // One-cycle reset with a taken jump on the inputs, which reset must override.
  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b0; branchen_i = 1'b1; branchtype_i = 3'b100;
    branchtarget_i = 16'hBEEF; regwrite_i = 1'b1; rd_addr_i = 5'd4;
    @(posedge clk); #1;
    checkOutput({tag, "_we"}, 32'(rf_we_o), 32'd0);
    checkOutput({tag, "_addr"}, 32'(rf_addr_o), 32'd0);
    checkOutput({tag, "_data"}, rf_data_o, 32'd0);
    checkOutput({tag, "_br"}, 32'(br_taken_o), 32'd0);
    checkOutput({tag, "_pc"}, 32'(br_pc_o), 32'd0);
    checkOutput({tag, "_flush"}, 32'(flush_o), 32'd0);
    m_left = 0; m_pc = '0; sb.delete();
    @(negedge clk);
    rst = 1'b1; branchen_i = 1'b0; regwrite_i = 1'b0; rd_addr_i = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    logic [31:0] mem_word = 32'h80FF_7F01;
    logic [2:0]  ld_types [8] = '{3'b011, 3'b011, 3'b010, 3'b001, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  ld_offs  [8] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};

    $display("[TB] starting wb_branch_resolve bench");
    doReset("reset");

    v = nop(); v.rw = 1; v.rd = 5'd7; v.p = 37'h0_1234_5678;
    applyStimulus("alu_r7", v);
    v.rd = 5'd0;
    applyStimulus("alu_r0", v);

    for (int i = 0; i < 8; i++) begin
      v = nop(); v.re = 1; v.rd = 5'd10 + 5'(i); v.mem = mem_word;
      v.lt = ld_types[i]; v.p = {35'h0, ld_offs[i]};
      applyStimulus($sformatf("load%0d", i), v);
    end

    v = nop(); v.sr = 1; v.rd = 5'd2; v.p = {1'b1, 36'h5}; v.cmpsel = 0;
    applyStimulus("sr_neg", v);
    v = nop(); v.sr = 1; v.rd = 5'd2; v.p = '0; v.cmpsel = 1;
    applyStimulus("sr_zero", v);
    v = nop(); v.sr = 1; v.rd = 5'd2; v.p = 37'h3; v.cmpsel = 1;
    applyStimulus("sr_nonzero", v);
    v = nop(); v.rwui = 1; v.rd = 5'd5; v.p = 37'h0_0000_ABCD;
    applyStimulus("lui", v);
    v = nop(); v.re = 1; v.sr = 1; v.rwui = 1; v.rd = 5'd6; v.mem = 32'hCAFE_F00D; v.lt = 3'b000;
    applyStimulus("prio_load", v);

    // Taken BEQ, then nine back-to-back writes: eight squashed, ninth lands.
    v = nop(); v.be = 1; v.bt = 3'b000; v.p = '0; v.tgt = 16'h0040;
    applyStimulus("beq_taken", v);
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = nop(); v.rw = 1; v.rd = 5'd3; v.p = 37'(i + 1);
      applyStimulus($sformatf("beq_shadow%0d", i), v);
    end

    v = nop(); v.be = 1; v.bt = 3'b001; v.p = '0; v.tgt = 16'h0077;
    applyStimulus("bne_not_taken", v);
    v.bt = 3'b101;
    applyStimulus("reserved_type", v);
    v = nop(); v.be = 1; v.bt = 3'b011; v.p = {1'b1, 36'h1}; v.tgt = 16'h0011;
    applyStimulus("bge_not_taken", v);
    applyStimulus("idle_after", nop());

    // Linking jump, then a second taken jump inside the squash window.
    v = nop(); v.be = 1; v.bt = 3'b100; v.rw = 1; v.rd = 5'd31;
    v.p = 37'h1_0000_0010; v.tgt = 16'h1234;
    applyStimulus("jmp_link", v);
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = nop(); v.rw = 1; v.rd = 5'd8; v.p = 37'h100 + 37'(i);
      if (i == 3) begin v.be = 1; v.bt = 3'b100; v.tgt = 16'h0099; end
      applyStimulus($sformatf("jmp_shadow%0d", i), v);
    end

    v = nop(); v.be = 1; v.bt = 3'b010; v.p = {1'b1, 36'h0}; v.tgt = 16'h0200;
    applyStimulus("blt_taken", v);
    applyStimulus("blt_sq0", nop());
    applyStimulus("blt_sq1", nop());
    doReset("reset_mid_squash");
    v = nop(); v.rw = 1; v.rd = 5'd3; v.p = 37'h5;
    applyStimulus("post_reset_write", v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
